// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Decoupled instruction-fetch engine. Issues in-order requests
//               to instruction memory, tracks the PC of every request in
//               flight, buffers returned words in a DEPTH-entry prefetch queue
//               and presents {pc, pc+4, instruction} to the IF/ID register.
//               An EX redirect flushes all wrong-path state. Responses still
//               in flight at that point are counted and discarded on return.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               imem_req_valid_o/ready_i  - fetch request handshake
//               imem_req_addr_o           - word-aligned fetch address
//               imem_rsp_valid_i/data_i   - in-order memory responses
//               redirect_valid_i/pc_i     - EX redirect target
//               out_valid_o/ready_i       - handshake towards IF/ID
//               out_pc_o/out_pc_plus_4_o  - PC of the head instruction, and PC+4
//               out_instruction_o         - head instruction word
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_pc_plus_4_o,
    output logic [31:0]     out_instruction_o
);

    localparam int unsigned c_AW = $clog2(DEPTH);  // pointer width
    localparam int unsigned c_CW = c_AW + 1;       // counter width, holds 0..DEPTH
    localparam int unsigned c_SW = c_CW + 1;       // width of inflight + count

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [c_CW-1:0] inflight_q, inflight_d;
    logic [c_CW-1:0] drop_q,     drop_d;
    logic [c_CW-1:0] q_cnt_q,    q_cnt_d;

    logic [XLEN-1:0] trk_pc_q [DEPTH];
    logic [c_AW-1:0] trk_wr_q, trk_wr_d;
    logic [c_AW-1:0] trk_rd_q, trk_rd_d;

    logic [XLEN-1:0] q_pc_q  [DEPTH];
    logic [31:0]     q_ins_q [DEPTH];
    logic [c_AW-1:0] q_wr_q, q_wr_d;
    logic [c_AW-1:0] q_rd_q, q_rd_d;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic [c_SW-1:0] w_occupancy;
    logic            w_credit;
    logic            w_req_fire;
    logic            w_rsp_fire;
    logic            w_rsp_push;
    logic            w_out_fire;
    logic            w_unused;

    // The low address bits of the redirect target are forced to zero.
    assign w_unused = ^redirect_pc_i[1:0];

    // Every request reserves a queue slot until its instruction is consumed,
    // so the queue can never be asked to accept more than it holds.
    assign w_occupancy = {1'b0, inflight_q} + {1'b0, q_cnt_q};
    assign w_credit    = (w_occupancy < c_SW'(DEPTH));

    assign imem_req_valid_o = !rst && !redirect_valid_i && w_credit;
    assign imem_req_addr_o  = fetch_pc_q;
    assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;

    // A response with nothing outstanding is a stray from before reset.
    assign w_rsp_fire = imem_rsp_valid_i && (inflight_q != '0);
    // Only right-path responses arriving outside a redirect cycle are kept.
    assign w_rsp_push = w_rsp_fire && (drop_q == '0) && !redirect_valid_i;

    assign out_valid_o       = !rst && !redirect_valid_i && (q_cnt_q != '0);
    assign w_out_fire        = out_valid_o && out_ready_i;
    assign out_pc_o          = q_pc_q[q_rd_q];
    assign out_pc_plus_4_o   = q_pc_q[q_rd_q] + XLEN'(4);
    assign out_instruction_o = q_ins_q[q_rd_q];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        q_cnt_d    = q_cnt_q;
        trk_wr_d   = trk_wr_q;
        trk_rd_d   = trk_rd_q;
        q_wr_d     = q_wr_q;
        q_rd_d     = q_rd_q;

        if (redirect_valid_i) begin
            // Everything still outstanding is wrong-path. A response landing
            // in this cycle is discarded, so it leaves the drop count as well.
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            inflight_d = inflight_q - c_CW'(w_rsp_fire);
            drop_d     = inflight_q - c_CW'(w_rsp_fire);
            q_cnt_d    = '0;
            trk_wr_d   = '0;
            trk_rd_d   = '0;
            q_wr_d     = '0;
            q_rd_d     = '0;
        end else begin
            if (w_req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                trk_wr_d   = trk_wr_q + c_AW'(1);
            end
            if (w_rsp_push) begin
                trk_rd_d = trk_rd_q + c_AW'(1);
                q_wr_d   = q_wr_q + c_AW'(1);
            end
            if (w_rsp_fire && (drop_q != '0)) begin
                drop_d = drop_q - c_CW'(1);
            end
            if (w_out_fire) begin
                q_rd_d = q_rd_q + c_AW'(1);
            end
            inflight_d = inflight_q + c_CW'(w_req_fire) - c_CW'(w_rsp_fire);
            q_cnt_d    = q_cnt_q + c_CW'(w_rsp_push) - c_CW'(w_out_fire);
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            q_cnt_q    <= '0;
            trk_wr_q   <= '0;
            trk_rd_q   <= '0;
            q_wr_q     <= '0;
            q_rd_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            q_cnt_q    <= q_cnt_d;
            trk_wr_q   <= trk_wr_d;
            trk_rd_q   <= trk_rd_d;
            q_wr_q     <= q_wr_d;
            q_rd_q     <= q_rd_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage arrays: contents are only meaningful behind valid pointers, so
    // they carry no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_req_fire) begin
            trk_pc_q[trk_wr_q] <= fetch_pc_q;
        end
        if (!rst && w_rsp_push) begin
            q_pc_q[q_wr_q]  <= trk_pc_q[trk_rd_q];
            q_ins_q[q_wr_q] <= imem_rsp_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_unit
// Description : Directed bench for fetch_prefetch_unit with an in-order
//               instruction memory model (data = addr ^ 0xC0DE0000).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_4;
    logic [31:0] out_instruction;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_valid_o  (imem_req_valid),
        .imem_req_ready_i  (imem_req_ready),
        .imem_req_addr_o   (imem_req_addr),
        .imem_rsp_valid_i  (imem_rsp_valid),
        .imem_rsp_data_i   (imem_rsp_data),
        .redirect_valid_i  (redirect_valid),
        .redirect_pc_i     (redirect_pc),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_pc_o          (out_pc),
        .out_pc_plus_4_o   (out_pc_plus_4),
        .out_instruction_o (out_instruction)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    lat         = 1;
    bit    stray       = 1'b0;

    int          s_cyc;
    logic        s_req_valid, s_out_valid, s_rsp;
    logic [31:0] s_addr, s_pc, s_pc4, s_instr;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed 0x%08h expected 0x%08h", tag, s_cyc, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, s_cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive the memory response, sample outputs mid-cycle,
    // record any accepted request, then advance to the next falling edge.
    task automatic step();
        mreq_t m;
        int    due;
        s_rsp          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rst) begin
            mq.delete();
        end else if (stray) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memdata(mq[0].addr);
            s_rsp          = 1'b1;
            void'(mq.pop_front());
        end
        #1;
        s_cyc       = cyc;
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_out_valid = out_valid;
        s_pc        = out_pc;
        s_pc4       = out_pc_plus_4;
        s_instr     = out_instruction;
        if (imem_req_valid && imem_req_ready && !rst) begin
            due = cyc + lat;
            if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
            m.addr = imem_req_addr;
            m.due  = due;
            mq.push_back(m);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stray          = 1'b0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        repeat (2) begin
            step();
            chkb("rst_req_valid", s_req_valid, 1'b0);
            chkb("rst_out_valid", s_out_valid, 1'b0);
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc);
        chkb({tag, "_valid"}, s_out_valid, 1'b1);
        chk({tag, "_pc"},     s_pc,    pc);
        chk({tag, "_pc4"},    s_pc4,   pc + 32'd4);
        chk({tag, "_instr"},  s_instr, memdata(pc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc, exp_req, prev_addr;
        int          outs, tb_infl, tb_cnt;
        bit          prev_stall;

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        @(negedge clk);

        // Streaming at one instruction per cycle with a 1-cycle memory.
        do_reset();
        lat = 1;
        for (int k = 0; k < 8; k++) begin
            step();
            chkb("stream_req_valid", s_req_valid, 1'b1);
            chk("stream_req_addr", s_addr, 32'(4 * k));
            if (k >= 2) chk_out("stream_out", 32'(4 * (k - 2)));
            else        chkb("stream_out_idle", s_out_valid, 1'b0);
        end

        // Back-pressure: exactly DEPTH requests, then drain in order.
        do_reset();
        lat       = 1;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k < 4) begin
                chkb("stall_req_valid", s_req_valid, 1'b1);
                chk("stall_req_addr", s_addr, 32'(4 * k));
            end else begin
                chkb("stall_req_blocked", s_req_valid, 1'b0);
            end
            if (k >= 2) chk_out("stall_head", 32'h0);
        end
        out_ready = 1'b1;
        for (int k = 8; k < 13; k++) begin
            step();
            chk_out("drain_out", 32'(4 * (k - 8)));
            if (k == 8) chkb("drain_req_still_full", s_req_valid, 1'b0);
            if (k == 9) begin
                chkb("drain_req_resume", s_req_valid, 1'b1);
                chk("drain_req_addr", s_addr, 32'h10);
            end
        end

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        lat = 3;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        chkb("redir3_req_valid", s_req_valid, 1'b0);
        chkb("redir3_out_valid", s_out_valid, 1'b0);
        redirect_valid = 1'b0;
        for (int k = 3; k < 7; k++) begin
            step();
            chkb("redir3_no_wrong_path", s_out_valid, 1'b0);
            if (k == 3) begin
                chkb("redir3_target_req", s_req_valid, 1'b1);
                chk("redir3_target_addr", s_addr, 32'h100);
            end
        end
        step();
        chk_out("redir3_first", 32'h100);
        step();
        chk_out("redir3_second", 32'h104);

        // Unaligned redirect in the same cycle as a response, then wrap-around.
        do_reset();
        lat = 1;
        step();
        step();
        step();
        chk_out("redir1_pre", 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        step();
        chkb("redir1_out_blocked", s_out_valid, 1'b0);
        chkb("redir1_req_blocked", s_req_valid, 1'b0);
        redirect_valid = 1'b0;
        step();
        chk("redir1_aligned_addr", s_addr, 32'h100);
        chkb("redir1_out_empty", s_out_valid, 1'b0);
        step();
        chkb("redir1_out_wait", s_out_valid, 1'b0);
        step();
        chk_out("redir1_first", 32'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        chkb("wrap_out_blocked", s_out_valid, 1'b0);
        redirect_valid = 1'b0;
        step();
        chk("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr_zero", s_addr, 32'h0);
        step();
        chk_out("wrap_out_top", 32'hFFFF_FFFC);
        step();
        chk_out("wrap_out_zero", 32'h0);

        // Reset mid-operation with requests in flight and instructions queued.
        do_reset();
        lat       = 3;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk_out("midrst_head", 32'h0);
        chkb("midrst_full", s_req_valid, 1'b0);
        rst = 1'b1;
        step();
        chkb("midrst_req_valid", s_req_valid, 1'b0);
        chkb("midrst_out_valid", s_out_valid, 1'b0);
        rst       = 1'b0;
        cyc       = 0;
        lat       = 1;
        out_ready = 1'b1;
        stray     = 1'b1;
        step();
        chkb("restart_req_valid", s_req_valid, 1'b1);
        chk("restart_req_addr", s_addr, 32'h0);
        chkb("restart_out_idle", s_out_valid, 1'b0);
        stray = 1'b0;
        step();
        chkb("stray_ignored", s_out_valid, 1'b0);
        step();
        chk_out("restart_first", 32'h0);

        // Random handshakes and latency over 1000 instructions.
        do_reset();
        exp_pc     = '0;
        exp_req    = '0;
        prev_addr  = '0;
        prev_stall = 1'b0;
        outs       = 0;
        tb_infl    = 0;
        tb_cnt     = 0;
        for (int n = 0; n < 20000 && outs < 1000; n++) begin
            lat            = $urandom_range(1, 3);
            imem_req_ready = ($urandom_range(0, 1) == 1);
            out_ready      = ($urandom_range(0, 3) != 0);
            step();
            if (prev_stall) begin
                chkb("rand_hold_valid", s_req_valid, 1'b1);
                chk("rand_hold_addr", s_addr, prev_addr);
            end
            if (s_req_valid && imem_req_ready) begin
                chk("rand_req_seq", s_addr, exp_req);
                exp_req = exp_req + 32'd4;
                tb_infl++;
            end
            if (s_rsp) begin
                tb_infl--;
                tb_cnt++;
            end
            if (s_out_valid && out_ready) begin
                chk("rand_out_pc", s_pc, exp_pc);
                chk("rand_out_pc4", s_pc4, exp_pc + 32'd4);
                chk("rand_out_instr", s_instr, memdata(exp_pc));
                exp_pc = exp_pc + 32'd4;
                outs++;
                tb_cnt--;
            end
            chkb("rand_credit", (tb_infl + tb_cnt) <= 4, 1'b1);
            prev_stall = s_req_valid && !imem_req_ready;
            prev_addr  = s_addr;
        end
        chk("rand_out_count", 32'(outs), 32'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
